// File: rtl/interleaver_pass_sequencer.sv
// interleaver_pass_sequencer
//
// Purpose:
//   Sequences interleaver address generation for one code block. After an
//   accepted start it latches the block size. It then walks 8 offset passes,
//   one offset at a time. Within each pass it steps the row index from 0 to
//   R-1 and emits addr = {row, offset} over a valid/ready handshake.
//
// Ports:
//   clk_i           clock
//   reset_i         synchronous, active-high reset
//   start_i         request to sequence one block (honoured only in IDLE)
//   block_size_i    0 = small block (132 rows), 1 = large block (768 rows)
//   addr_ready_i    downstream accepts addr_o this cycle
//   addr_o          {row, offset}
//   addr_valid_o    addr_o is valid (RUN state)
//   last_in_pass_o  addr_o is the last row of the current pass
//   last_in_block_o addr_o is the last address of the block
//   pass_done_o     one-cycle pulse after the last handshake of each pass
//   done_o          one-cycle pulse after the last handshake of the block
//   busy_o          high from the cycle after start through the done cycle
module interleaver_pass_sequencer #(
  parameter int ROW_W      = 10,
  parameter int OFF_W      = 3,
  parameter int SMALL_ROWS = 132,
  parameter int LARGE_ROWS = 768
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   block_size_i,
  input  logic                   addr_ready_i,
  output logic [ROW_W+OFF_W-1:0] addr_o,
  output logic                   addr_valid_o,
  output logic                   last_in_pass_o,
  output logic                   last_in_block_o,
  output logic                   pass_done_o,
  output logic                   done_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [ROW_W-1:0] SMALL_LAST = ROW_W'(SMALL_ROWS - 1);
  localparam logic [ROW_W-1:0] LARGE_LAST = ROW_W'(LARGE_ROWS - 1);

  state_t             state_q;
  logic [ROW_W-1:0]   row_q;
  logic [OFF_W-1:0]   off_q;
  logic               large_q;
  logic               passDone_q;
  logic               done_q;

  logic [ROW_W-1:0]   rowLast;
  logic               rowEnd;
  logic               offEnd;
  logic               handshake;

  // The latched size selects the last row index for every pass of the block.
  assign rowLast   = large_q ? LARGE_LAST : SMALL_LAST;
  assign rowEnd    = (row_q == rowLast);
  assign offEnd    = (off_q == '1);
  assign handshake = (state_q == RUN) && addr_ready_i;

  assign addr_o          = {row_q, off_q};
  assign addr_valid_o    = (state_q == RUN);
  assign busy_o          = (state_q != IDLE);
  assign last_in_pass_o  = (state_q == RUN) && rowEnd;
  assign last_in_block_o = (state_q == RUN) && rowEnd && offEnd;
  assign pass_done_o     = passDone_q;
  assign done_o          = done_q;

  // Single sequencer: the row steps on each handshake. On the last row the
  // offset advances, with no bubble between passes. The final handshake
  // moves to DONE. row and offset return to zero there, so addr is 0 outside RUN.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      row_q      <= '0;
      off_q      <= '0;
      large_q    <= 1'b0;
      passDone_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      passDone_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            large_q <= block_size_i;
            row_q   <= '0;
            off_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (handshake) begin
            if (!rowEnd) begin
              row_q <= row_q + 1'b1;
            end else begin
              row_q      <= '0;
              passDone_q <= 1'b1;
              if (offEnd) begin
                off_q   <= '0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                off_q <= off_q + 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
